// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB slave register file.
// The FSM states, the 9-bit phase length and the R/W bit encoding live here.
package sccb_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ID,
        ST_ID_ACK,
        ST_SUB,
        ST_SUB_ACK,
        ST_WDAT,
        ST_WDAT_ACK,
        ST_RDAT,
        ST_RDAT_NA,
        ST_IGNORE
    } sccb_slv_state_e;

    localparam int   SCCB_PHASE_BITS = 9;
    localparam logic SCCB_RW_WRITE   = 1'b0;
    localparam logic SCCB_RW_READ    = 1'b1;

endpackage

// File: rtl/sccb_bus_sync.sv
// Synchronizes sio_c/sio_d into the clk domain and flags SCL edges and
// START/STOP conditions, each as a single-cycle pulse.
module sccb_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sio_c_i,
    input  logic sio_d_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;
    logic                   sda_s;

    // Idle bus level is high, so the chains reset to 1 to avoid false edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= (scl_sync_q << 1) | SYNC_STAGES'(sio_c_i);
            sda_sync_q <= (sda_sync_q << 1) | SYNC_STAGES'(sio_d_i);
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];
    assign sda_o      = sda_s;
    assign scl_rise_o = scl_s & ~scl_prev_q;
    assign scl_fall_o = ~scl_s & scl_prev_q;
    assign start_o    = scl_s & scl_prev_q & ~sda_s & sda_prev_q;
    assign stop_o     = scl_s & scl_prev_q & sda_s & ~sda_prev_q;

endmodule

// File: rtl/sccb_slave_regfile.sv
// SCCB slave with a 256 x 8 register file: 3-phase writes, 2-phase reads,
// auto-incrementing pointer, local read port and a write-event strobe.
module sccb_slave_regfile
    import sccb_pkg::*;
#(
    parameter logic [6:0] SLAVE_ID    = 7'h21,
    parameter logic [7:0] REG_RST_VAL = 8'h00,
    parameter int         SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sio_c,
    inout  wire             sio_d,
    input  logic [7:0]      loc_addr_i,
    output logic [7:0]      loc_data_o,
    output logic            wr_evt_o,
    output logic [7:0]      wr_addr_o,
    output logic [7:0]      wr_data_o,
    output logic            busy_o,
    output sccb_slv_state_e state_o
);

    localparam logic [3:0] LAST_DATA_BIT = 4'd7;
    localparam logic [3:0] ACK_BIT       = 4'(SCCB_PHASE_BITS - 1);
    localparam logic [3:0] ACK_SEEN      = 4'(SCCB_PHASE_BITS);

    sccb_slv_state_e state_q, state_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      rx_q, rx_d;
    logic [7:0]      tx_q, tx_d;
    logic [7:0]      ptr_q, ptr_d;
    logic            drv_q, drv_d;
    logic            busy_q, busy_d;
    logic            wr_evt_q;
    logic [7:0]      wr_addr_q, wr_data_q;
    logic [7:0]      regs_q [256];
    logic            wr_en;
    logic [7:0]      rx_byte;
    logic            sda_s, scl_rise, scl_fall, start_det, stop_det;

    sccb_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .rst        (rst),
        .sio_c_i    (sio_c),
        .sio_d_i    (sio_d),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_det),
        .stop_o     (stop_det)
    );

    assign rx_byte = {rx_q[6:0], sda_s};

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        ptr_d     = ptr_q;
        drv_d     = drv_q;
        busy_d    = busy_q;
        wr_en     = 1'b0;
        if (stop_det) begin
            state_d   = ST_IDLE;
            drv_d     = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = '0;
        end else if (start_det) begin
            state_d   = ST_ID;
            drv_d     = 1'b0;
            busy_d    = 1'b1;
            bit_cnt_d = '0;
        end else begin
            unique case (state_q)
                ST_ID, ST_SUB, ST_WDAT: begin
                    if (scl_rise) begin
                        rx_d      = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == LAST_DATA_BIT) begin
                            case (state_q)
                                ST_ID:   state_d = (rx_byte[7:1] == SLAVE_ID) ? ST_ID_ACK : ST_IGNORE;
                                ST_SUB: begin
                                    ptr_d   = rx_byte;
                                    state_d = ST_SUB_ACK;
                                end
                                default: begin
                                    wr_en   = 1'b1;
                                    ptr_d   = ptr_q + 8'd1;
                                    state_d = ST_WDAT_ACK;
                                end
                            endcase
                        end
                    end
                end
                // First falling edge starts the ACK drive, the second ends the phase.
                ST_ID_ACK, ST_SUB_ACK, ST_WDAT_ACK: begin
                    if (scl_fall) begin
                        if (!drv_q) begin
                            drv_d = 1'b1;
                        end else begin
                            drv_d     = 1'b0;
                            bit_cnt_d = '0;
                            if (state_q == ST_ID_ACK && rx_q[0] == SCCB_RW_READ) begin
                                tx_d    = regs_q[ptr_q];
                                drv_d   = ~regs_q[ptr_q][7];
                                state_d = ST_RDAT;
                            end else if (state_q == ST_ID_ACK && rx_q[0] == SCCB_RW_WRITE) begin
                                state_d = ST_SUB;
                            end else begin
                                state_d = ST_WDAT;
                            end
                        end
                    end
                end
                ST_RDAT: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == ACK_BIT) begin
                            drv_d   = 1'b0;
                            ptr_d   = ptr_q + 8'd1;
                            state_d = ST_RDAT_NA;
                        end else begin
                            tx_d  = {tx_q[6:0], tx_q[7]};
                            drv_d = ~tx_q[6];
                        end
                    end
                end
                ST_RDAT_NA: begin
                    if (scl_rise && bit_cnt_q == ACK_BIT) begin
                        if (sda_s) state_d = ST_IGNORE;
                        else       bit_cnt_d = ACK_SEEN;
                    end else if (scl_fall && bit_cnt_q == ACK_SEEN) begin
                        tx_d      = regs_q[ptr_q];
                        drv_d     = ~regs_q[ptr_q][7];
                        bit_cnt_d = '0;
                        state_d   = ST_RDAT;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            ptr_q     <= '0;
            drv_q     <= 1'b0;
            busy_q    <= 1'b0;
            wr_evt_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            ptr_q     <= ptr_d;
            drv_q     <= drv_d;
            busy_q    <= busy_d;
            wr_evt_q  <= wr_en;
            if (wr_en) begin
                wr_addr_q <= ptr_q;
                wr_data_q <= rx_byte;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) regs_q[i] <= REG_RST_VAL;
        end else if (wr_en) begin
            regs_q[ptr_q] <= rx_byte;
        end
    end

    assign sio_d      = drv_q ? 1'b0 : 1'bz;
    assign loc_data_o = regs_q[loc_addr_i];
    assign wr_evt_o   = wr_evt_q;
    assign wr_addr_o  = wr_addr_q;
    assign wr_data_o  = wr_data_q;
    assign busy_o     = busy_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_sccb_slave_regfile.sv
// Directed bench for sccb_slave_regfile: a bit-banged SCCB master, a table of
// write transactions and hand-written read, wrap, abort and reset sequences.
module tb_sccb_slave_regfile;
    import sccb_pkg::*;

    localparam int Q = 50;

    typedef struct {
        logic [7:0] id;
        logic [7:0] sub;
        logic [7:0] data;
        logic [2:0] exp_ack;
        int         exp_evt;
        logic [7:0] exp_loc;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            sio_c;
    logic            m_sda;
    logic [7:0]      loc_addr_i;
    logic [7:0]      loc_data_o;
    logic            wr_evt_o;
    logic [7:0]      wr_addr_o;
    logic [7:0]      wr_data_o;
    logic            busy_o;
    sccb_slv_state_e state_o;
    wire             sio_d;

    int checks = 0;
    int errors = 0;
    int evt_cnt = 0;
    int slave_low = 0;

    pullup (sio_d);
    assign sio_d = m_sda ? 1'bz : 1'b0;

    sccb_slave_regfile dut (
        .clk        (clk),
        .rst        (rst),
        .sio_c      (sio_c),
        .sio_d      (sio_d),
        .loc_addr_i (loc_addr_i),
        .loc_data_o (loc_data_o),
        .wr_evt_o   (wr_evt_o),
        .wr_addr_o  (wr_addr_o),
        .wr_data_o  (wr_data_o),
        .busy_o     (busy_o),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wr_evt_o) evt_cnt++;
    always @(posedge clk) if (m_sda && sio_d === 1'b0) slave_low++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic peek(input logic [7:0] a, output logic [7:0] d);
        loc_addr_i = a;
        #1;
        d = loc_data_o;
        #9;
    endtask

    task automatic send_bit(input logic b, output logic s);
        #Q; m_sda = b;
        #Q; sio_c = 1'b1;
        #Q; s = (sio_d !== 1'b0);
        #Q; sio_c = 1'b0;
    endtask

    task automatic bus_start();
        #Q; m_sda = 1'b1;
        #Q; sio_c = 1'b1;
        #Q; m_sda = 1'b0;
        #Q; sio_c = 1'b0;
    endtask

    task automatic bus_stop();
        #Q; m_sda = 1'b0;
        #Q; sio_c = 1'b1;
        #Q; m_sda = 1'b1;
        #Q;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], s);
        send_bit(1'b1, s);
        acked = ~s;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1, s);
            d = {d[6:0], s};
        end
        send_bit(nack, s);
    endtask

    initial begin
        vec_t       vec [7];
        logic [2:0] a;
        logic       ack, s;
        logic [7:0] d;
        int         e0, d0;

        vec[0] = '{8'h42, 8'h2A, 8'h11, 3'b111, 1, 8'h11};
        vec[1] = '{8'h42, 8'h2B, 8'hA5, 3'b111, 1, 8'hA5};
        vec[2] = '{8'h42, 8'h2C, 8'h5E, 3'b111, 1, 8'h5E};
        vec[3] = '{8'h60, 8'h2A, 8'h99, 3'b000, 0, 8'h11};
        vec[4] = '{8'h42, 8'h80, 8'hC3, 3'b111, 1, 8'hC3};
        vec[5] = '{8'h44, 8'h80, 8'h00, 3'b000, 0, 8'hC3};
        vec[6] = '{8'h42, 8'h80, 8'h3C, 3'b111, 1, 8'h3C};

        rst = 1'b1; sio_c = 1'b1; m_sda = 1'b1; loc_addr_i = '0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy_o, 0);
        check("rst_evt", wr_evt_o, 0);
        check("rst_addr", wr_addr_o, 0);
        check("rst_data", wr_data_o, 0);
        check("rst_state", 32'(state_o), 32'(ST_IDLE));
        check("rst_sda_low", sio_d === 1'b0, 0);
        peek(8'h00, d); check("rst_reg00", d, 8'h00);
        peek(8'hFF, d); check("rst_regFF", d, 8'h00);

        for (int v = 0; v < 7; v++) begin
            e0 = evt_cnt; d0 = slave_low;
            bus_start();
            check($sformatf("v%0d_busy", v), busy_o, 1);
            write_byte(vec[v].id, a[2]);
            write_byte(vec[v].sub, a[1]);
            write_byte(vec[v].data, a[0]);
            bus_stop();
            check($sformatf("v%0d_ack", v), a, vec[v].exp_ack);
            check($sformatf("v%0d_evt", v), evt_cnt - e0, vec[v].exp_evt);
            check($sformatf("v%0d_drove", v), slave_low != d0, vec[v].exp_ack != 3'b000);
            if (vec[v].exp_evt != 0) begin
                check($sformatf("v%0d_waddr", v), wr_addr_o, vec[v].sub);
                check($sformatf("v%0d_wdata", v), wr_data_o, vec[v].data);
            end
            peek(vec[v].sub, d);
            check($sformatf("v%0d_loc", v), d, vec[v].exp_loc);
            check($sformatf("v%0d_idle_busy", v), busy_o, 0);
        end

        bus_start(); write_byte(8'h42, a[2]); write_byte(8'h2A, a[1]); bus_stop();
        bus_start(); write_byte(8'h43, a[0]);
        check("rd_acks", a, 3'b111);
        read_byte(1'b0, d); check("rd_byte0", d, 8'h11);
        read_byte(1'b1, d); check("rd_byte1", d, 8'hA5);
        bus_stop();
        bus_start(); write_byte(8'h43, ack);
        read_byte(1'b1, d); check("rd_ptr_kept", d, 8'h5E);
        bus_stop();

        e0 = evt_cnt;
        bus_start(); write_byte(8'h42, a[2]); write_byte(8'hFF, a[1]);
        write_byte(8'h3F, a[0]); write_byte(8'h55, ack);
        bus_stop();
        check("wrap_acks", {a, ack}, 4'b1111);
        check("wrap_evt", evt_cnt - e0, 2);
        check("wrap_waddr", wr_addr_o, 8'h00);
        peek(8'hFF, d); check("wrap_regFF", d, 8'h3F);
        peek(8'h00, d); check("wrap_reg00", d, 8'h55);

        e0 = evt_cnt;
        bus_start(); write_byte(8'h42, a[2]); write_byte(8'h10, a[1]);
        send_bit(1'b1, s); send_bit(1'b0, s); send_bit(1'b1, s); send_bit(1'b0, s);
        bus_stop();
        check("abort_evt", evt_cnt - e0, 0);
        check("abort_state", 32'(state_o), 32'(ST_IDLE));
        peek(8'h10, d); check("abort_reg", d, 8'h00);
        bus_start(); write_byte(8'h42, a[2]); write_byte(8'h10, a[1]); write_byte(8'h77, a[0]);
        bus_stop();
        check("after_abort_evt", evt_cnt - e0, 1);
        peek(8'h10, d); check("after_abort_reg", d, 8'h77);

        bus_start(); write_byte(8'h42, a[2]); write_byte(8'h2A, a[1]); bus_stop();
        bus_start(); write_byte(8'h43, ack);
        check("rrst_ack", ack, 1);
        #60;
        check("rrst_driving", sio_d === 1'b0, 1);
        check("rrst_state", 32'(state_o), 32'(ST_RDAT));
        rst = 1'b1;
        #10;
        check("rrst_released", sio_d === 1'b0, 0);
        check("rrst_busy", busy_o, 0);
        check("rrst_state_idle", 32'(state_o), 32'(ST_IDLE));
        #10;
        rst = 1'b0;
        peek(8'h2A, d); check("rrst_reg2A", d, 8'h00);
        peek(8'h10, d); check("rrst_reg10", d, 8'h00);
        peek(8'hFF, d); check("rrst_regFF", d, 8'h00);
        bus_stop();
        check("rrst_still_idle", 32'(state_o), 32'(ST_IDLE));
        bus_start(); write_byte(8'h42, a[2]); write_byte(8'h01, a[1]); write_byte(8'h5A, a[0]);
        bus_stop();
        check("recover_acks", a, 3'b111);
        peek(8'h01, d); check("recover_reg", d, 8'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
